// File: rtl/bin_bcd_7seg_seq.sv
// Serial binary-to-BCD converter (shift-add-3) with registered BCD, overflow
// and active-low 7-segment outputs for the lab board display bank.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one add-3/shift step per cycle, N steps total
// LOAD  | publish wb to bcd/seg/ovf and pulse done
module bin_bcd_7seg_seq #(
    parameter int N        = 8,
    parameter int D        = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic [4*D-1:0]   bcd,
    output logic [7*D-1:0]   seg,
    output logic             ovf
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t          state_q;
    logic [N-1:0]    sr_q, sr_d;
    logic [4*D-1:0]  wb_q, wb_d, wb_adj;
    logic            sticky_q, carry;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q, ovf_q;
    logic [4*D-1:0]  bcd_q;
    logic [7*D-1:0]  seg_q, seg_d;

    function automatic logic [6:0] seg7(input logic [3:0] dg);
        case (dg)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Walk from the most significant digit down; a digit is blanked while
    // everything at and above it is still zero. Digit 0 always shows.
    function automatic logic [7*D-1:0] decode(input logic [4*D-1:0] v);
        logic       lead;
        logic [3:0] dg;
        decode = '0;
        lead   = 1'b1;
        for (int i = D - 1; i >= 0; i--) begin
            dg = v[4*i +: 4];
            if (dg != 4'd0) lead = 1'b0;
            if ((BLANK_LZ != 0) && lead && (i > 0))
                decode[7*i +: 7] = 7'b1111111;
            else
                decode[7*i +: 7] = seg7(dg);
        end
    endfunction

    // One double-dabble step: correct every digit >= 5, then shift {wb, sr}.
    always_comb begin
        wb_adj = wb_q;
        for (int i = 0; i < D; i++) begin
            if (wb_q[4*i +: 4] >= 4'd5)
                wb_adj[4*i +: 4] = wb_q[4*i +: 4] + 4'd3;
        end
        {carry, wb_d, sr_d} = {wb_adj, sr_q, 1'b0};
    end

    // Segment patterns for the working value, registered only on LOAD.
    always_comb begin
        seg_d = decode(wb_q);
    end

    // Control FSM and all output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            wb_q     <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bcd_q    <= '0;
            seg_q    <= decode('0);
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_q     <= bin;
                        wb_q     <= '0;
                        sticky_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q     <= sr_d;
                    wb_q     <= wb_d;
                    sticky_q <= sticky_q | carry;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1))
                        state_q <= LOAD;
                end
                LOAD: begin
                    bcd_q   <= wb_q;
                    ovf_q   <= sticky_q;
                    seg_q   <= seg_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign seg  = seg_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_bcd_7seg_seq.sv
// Bench for bin_bcd_7seg_seq: four instances (8b/3d blanked, 8b/3d unblanked,
// 8b/2d blanked, 16b/5d blanked) checked against an arithmetic decimal model.
module tb_bin_bcd_7seg_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [7:0]  bin_a;
    logic [15:0] bin_b;

    logic        busy_a0, done_a0, ovf_a0;
    logic [11:0] bcd_a0;
    logic [20:0] seg_a0;
    logic        busy_a1, done_a1, ovf_a1;
    logic [11:0] bcd_a1;
    logic [20:0] seg_a1;
    logic        busy_a2, done_a2, ovf_a2;
    logic [7:0]  bcd_a2;
    logic [13:0] seg_a2;
    logic        busy_b, done_b, ovf_b;
    logic [19:0] bcd_b;
    logic [34:0] seg_b;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

    always #5 clk = ~clk;

    bin_bcd_7seg_seq #(.N(8), .D(3), .BLANK_LZ(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
        .busy(busy_a0), .done(done_a0), .bcd(bcd_a0), .seg(seg_a0), .ovf(ovf_a0));
    bin_bcd_7seg_seq #(.N(8), .D(3), .BLANK_LZ(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
        .busy(busy_a1), .done(done_a1), .bcd(bcd_a1), .seg(seg_a1), .ovf(ovf_a1));
    bin_bcd_7seg_seq #(.N(8), .D(2), .BLANK_LZ(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
        .busy(busy_a2), .done(done_a2), .bcd(bcd_a2), .seg(seg_a2), .ovf(ovf_a2));
    bin_bcd_7seg_seq #(.N(16), .D(5), .BLANK_LZ(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .seg(seg_b), .ovf(ovf_b));

    function automatic int pow10(input int nd);
        int p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [63:0] ref_bcd(input int val, input int nd);
        logic [63:0] r = '0;
        int p = 1;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'((val / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_seg(input int val, input int nd, input bit blank);
        logic [63:0] r = '0;
        int rv = val % pow10(nd);
        int p = 1;
        for (int i = 0; i < nd; i++) begin
            if (blank && i > 0 && rv < p) r[7*i +: 7] = 7'b1111111;
            else                          r[7*i +: 7] = seg_tbl[(rv / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy0"}, busy_a0, 0);
        chk({tag, "_done0"}, done_a0, 0);
        chk({tag, "_ovf0"},  ovf_a0, 0);
        chk({tag, "_bcd0"},  bcd_a0, 0);
        chk({tag, "_seg0"},  seg_a0, {7'b1111111, 7'b1111111, 7'b0000001});
        chk({tag, "_seg1"},  seg_a1, {7'b0000001, 7'b0000001, 7'b0000001});
        chk({tag, "_bcd2"},  bcd_a2, 0);
        chk({tag, "_seg2"},  seg_a2, {7'b1111111, 7'b0000001});
        chk({tag, "_bcdb"},  bcd_b, 0);
        chk({tag, "_busyb"}, busy_b, 0);
    endtask

    // One conversion on the 8-bit instances; bin scrambled after acceptance,
    // optional start pulses while busy.
    task automatic conv_a(input logic [7:0] v, input bit noisy);
        int busy_cnt, done_m, extra;
        @(negedge clk); bin_a = v; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk); start_a = 1'b0;
        busy_cnt = 0; done_m = -1;
        for (int m = 0; m < 30; m++) begin
            if (done_a0) begin done_m = m; break; end
            if (busy_a0) busy_cnt++;
            bin_a   = 8'($urandom);
            start_a = (noisy && m < 6 && (m % 2 == 0)) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start_a = 1'b0;
        chk("a_done_lat", 64'(done_m), 9);
        chk("a_busy_len", 64'(busy_cnt), 9);
        chk("a_busy_at_done", busy_a0, 0);
        chk("u0_bcd", bcd_a0, ref_bcd(v, 3));
        chk("u0_seg", seg_a0, ref_seg(v, 3, 1));
        chk("u0_ovf", ovf_a0, 0);
        chk("u1_done", done_a1, 1);
        chk("u1_seg", seg_a1, ref_seg(v, 3, 0));
        chk("u2_done", done_a2, 1);
        chk("u2_bcd", bcd_a2, ref_bcd(v % 100, 2));
        chk("u2_seg", seg_a2, ref_seg(v, 2, 1));
        chk("u2_ovf", ovf_a2, 64'(v >= 100));
        extra = 0;
        for (int m = 0; m < 12; m++) begin
            @(negedge clk);
            if (done_a0) extra++;
        end
        chk("a_extra_done", 64'(extra), 0);
        chk("u0_bcd_hold", bcd_a0, ref_bcd(v, 3));
    endtask

    task automatic conv_b(input logic [15:0] v);
        int busy_cnt, done_m;
        @(negedge clk); bin_b = v; start_b = 1'b1;
        @(posedge clk);
        @(negedge clk); start_b = 1'b0;
        busy_cnt = 0; done_m = -1;
        for (int m = 0; m < 40; m++) begin
            if (done_b) begin done_m = m; break; end
            if (busy_b) busy_cnt++;
            bin_b = 16'($urandom);
            @(negedge clk);
        end
        chk("b_done_lat", 64'(done_m), 17);
        chk("b_busy_len", 64'(busy_cnt), 17);
        chk("u3_bcd", bcd_b, ref_bcd(v, 5));
        chk("u3_seg", seg_b, ref_seg(v, 5, 1));
        chk("u3_ovf", ovf_b, 0);
        @(negedge clk);
        chk("b_done_pulse", done_b, 0);
    endtask

    initial begin
        logic [7:0] seq [4];
        int cyc, nd, dn;

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;

        conv_a(8'd255, 1'b0);
        conv_a(8'd7,   1'b0);
        conv_a(8'd100, 1'b0);
        conv_a(8'd99,  1'b0);
        conv_a(8'd0,   1'b0);
        conv_a(8'd42,  1'b1);
        for (int r = 0; r < 16; r++) conv_a(8'($urandom_range(0, 255)), r[0]);

        conv_b(16'd65535);
        conv_b(16'd0);
        conv_b(16'd10000);
        for (int r = 0; r < 5; r++) conv_b(16'($urandom));

        // Reset in the middle of a conversion, with a nonzero result on display.
        conv_a(8'd255, 1'b0);
        @(negedge clk); bin_a = 8'd42; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk); start_a = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midrst");
        rst_n = 1'b1;
        dn = 0;
        for (int m = 0; m < 20; m++) begin
            @(negedge clk);
            if (done_a0) dn++;
        end
        chk("midrst_no_done", 64'(dn), 0);
        chk("midrst_bcd_hold", bcd_a0, 0);

        // start held high: back-to-back conversions alternating 0 and 128.
        seq[0] = 8'd0; seq[1] = 8'd128; seq[2] = 8'd0; seq[3] = 8'd128;
        @(negedge clk); bin_a = seq[0]; start_a = 1'b1;
        cyc = 0; nd = 0;
        for (int t = 0; t < 60 && nd < 4; t++) begin
            @(negedge clk);
            cyc++;
            if (done_a0) begin
                chk("b2b_bcd", bcd_a0, ref_bcd(seq[nd], 3));
                chk("b2b_gap", 64'(cyc), 10);
                cyc = 0;
                nd++;
                if (nd < 4) bin_a = seq[nd];
                else        start_a = 1'b0;
            end
        end
        start_a = 1'b0;
        chk("b2b_count", 64'(nd), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
